uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the memory-mapped UART component's transmitter between NUM_REQ byte producers, e.g. CPU console, debug monitor and boot loader.
Acts as a bus master on the UART's cs/wr/rd_strobe/addr port. For each byte it:
- picks a requester round-robin,
- polls the UART control register until TX_BUSY is clear,
- writes the byte to the Tx buffer,
- acknowledges the requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
POLL_GAP, 4, idle cycles between consecutive busy polls (0 = back-to-back).
TIMEOUT_CYCLES, 65535, poll-loop cycle limit (used only with UART_ARB_TIMEOUT_EN).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a byte pending
req_data  in  NUM_REQ*8  byte of requester i at bits [8i+7:8i]
req_ready  out  NUM_REQ  one-cycle pulse: requester i's byte written to UART
grant_id  out  3  index of current/last granted requester
busy  out  1  high whenever state != ARB_IDLE
uart_cs  out  1  UART chip select, active low
uart_wr  out  1  UART write, active low
uart_rd_strobe  out  1  UART read-start pulse
uart_rd_busy  in  1  UART read-busy
uart_addr  out  3  UART register address
uart_wdata  out  8  data to UART
uart_rdata  in  8  data from UART

Behaviour:
- Reset (any state) forces the following, effective the next cycle:
  - state=ARB_IDLE; uart_cs=1, uart_wr=1, uart_rd_strobe=0, uart_addr=0, uart_wdata=0
  - req_ready=0, grant_id=0, busy=0
  - RR pointer last=NUM_REQ-1, so requester 0 wins first
  - An abandoned poll or write is not retried. The latched byte is lost and that requester is not acked.
- Handshake:
  - Requester holds valid and data stable until it sees its req_ready pulse.
  - The byte is latched at grant. A valid drop after grant does not cancel the transfer.
- ARB_IDLE: when any req_valid is high, pick the first valid index searching last+1, last+2, … (mod NUM_REQ). Latch grant_id and data, then go to ARB_POLL.
- ARB_POLL: uart_cs=0, uart_addr=0 (control register), uart_rd_strobe=1 for exactly one cycle, then ARB_CAPTURE.
- ARB_CAPTURE:
  - Hold uart_cs=0, uart_addr=0 and wait for uart_rd_busy=1, then sample uart_rdata.
  - If bit CTL_TX_BUSY=1: go to ARB_GAP (counter=POLL_GAP), or directly to ARB_POLL when POLL_GAP=0.
  - Otherwise go to ARB_WRITE.
- ARB_GAP: bus idle (uart_cs=1); count down; at 0 go to ARB_POLL.
- ARB_WRITE:
  - Exactly one cycle with uart_cs=0, uart_wr=0, uart_addr=2, uart_wdata=latched byte.
  - req_ready[grant_id]=1 in the same cycle; last<=grant_id.
  - Next state ARB_SETTLE.
- ARB_SETTLE: one bus-idle cycle so the UART's TX_BUSY update is visible, then ARB_IDLE.
- Latency: valid seen in ARB_IDLE at cycle 0 with UART idle gives ARB_WRITE and req_ready at cycle 3. Back-to-back bytes are spaced at least 5 cycles.
- uart_wr is low only in ARB_WRITE. uart_rd_strobe is never high in consecutive cycles.
- grant_id holds its value after completion until the next grant.

Optional Feature:
UART_ARB_TIMEOUT_EN.
- Enabled:
  - A counter runs from entry to ARB_POLL until ARB_WRITE and adds output port timeout_err (1 bit).
  - When the counter reaches TIMEOUT_CYCLES, the block aborts to ARB_IDLE without a write, pulses req_ready[grant_id] together with timeout_err for one cycle, and advances last.
- Disabled: the block polls indefinitely; no timeout_err port.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum ArbState {ARB_IDLE, ARB_POLL, ARB_CAPTURE, ARB_GAP, ARB_WRITE, ARB_SETTLE}
  - UART address constants UART_ADDR_CTRL=3'b000, UART_ADDR_TX=3'b010
  - control bit constants CTL_RX_AVAL=0, CTL_TX_BUSY=1, CTL_IRQ_ENAB=2
- Sub-module rr_arbiter: combinational round-robin winner from req_valid and last, with an any_valid output.

Test Plan:
1. Single requester: req 0 sends 0x41 while the UART model reports TX_BUSY=0 → write at addr 2 with data 0x41 at cycle 3, req_ready[0] pulses once, busy falls 2 cycles later.
2. Busy polling with POLL_GAP=2: model returns TX_BUSY=1 for 3 polls → exactly 4 rd_strobe pulses, each separated by a 2-cycle idle gap, then one write.
3. Round robin: requesters 0–3 hold valid continuously with bytes 0x10..0x13 → write sequence 0x10, 0x11, 0x12, 0x13, 0x10; no requester starved.
4. Reset mid-operation: assert reset while in ARB_CAPTURE → the next cycle has uart_cs=1, busy=0, no write ever issued for that byte; the next grant goes to requester 0.
5. Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50) with TX_BUSY stuck at 1 → no write, req_ready and timeout_err pulse together, then the next requester is served.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, UART register
// map and control-register bit positions.
package uart_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_POLL,
    ARB_CAPTURE,
    ARB_GAP,
    ARB_WRITE,
    ARB_SETTLE
  } arb_state_t;

  localparam logic [2:0] UART_ADDR_CTRL = 3'b000;
  localparam logic [2:0] UART_ADDR_TX   = 3'b010;

  localparam int CTL_RX_AVAL  = 0;
  localparam int CTL_TX_BUSY  = 1;
  localparam int CTL_IRQ_ENAB = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid index after `last`, wrapping
// modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [2:0]         last,
  output logic [2:0]         winner,
  output logic               any_valid
);

  int idx;

  // Walk from the farthest candidate to the nearest so the nearest overwrites.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == idx && req_valid[j]) winner = 3'(j);
      end
    end
    any_valid = |req_valid;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of a memory-mapped UART transmitter between NUM_REQ byte
// producers. Define UART_ARB_TIMEOUT_EN to add a poll-loop timeout and timeout_err.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int POLL_GAP       = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 uart_cs,
  output logic                 uart_wr,
  output logic                 uart_rd_strobe,
  input  logic                 uart_rd_busy,
  output logic [2:0]           uart_addr,
  output logic [7:0]           uart_wdata,
  input  logic [7:0]           uart_rdata
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  // Handshake: requester i holds req_valid[i] and its byte stable until the
  // one-cycle req_ready[i] pulse; the byte is captured at grant, so a later
  // drop of req_valid does not cancel the transfer.

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  arb_state_t    state, next_state;
  logic [2:0]    last;
  logic [2:0]    winner;
  logic          any_valid;
  logic [7:0]    data_q;
  logic [7:0]    sel_data;
  logic [GW-1:0] gap_cnt;
  logic          ack;
  logic          unused_rdata;

  assign unused_rdata = ^{uart_rdata[7:CTL_TX_BUSY+1], uart_rdata[CTL_RX_AVAL]};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_valid (req_valid),
    .last      (last),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == 3'(i)) sel_data = req_data[i*8 +: 8];
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          polling;

  assign polling = (state == ARB_POLL) || (state == ARB_CAPTURE) || (state == ARB_GAP);

  always_ff @(posedge clock) begin
    if (reset || state == ARB_IDLE) tmo_cnt <= '0;
    else if (polling && tmo_cnt != TW'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ARB_IDLE;
      last     <= 3'(NUM_REQ - 1);
      grant_id <= '0;
      data_q   <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= next_state;
      if (state == ARB_IDLE && any_valid) begin
        grant_id <= winner;
        data_q   <= sel_data;
      end
      if (state == ARB_CAPTURE) gap_cnt <= GAP_LOAD;
      else if (state == ARB_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      if (ack) last <= grant_id;
    end
  end

  always_comb begin
    next_state     = state;
    uart_cs        = 1'b1;
    uart_wr        = 1'b1;
    uart_rd_strobe = 1'b0;
    uart_addr      = UART_ADDR_CTRL;
    uart_wdata     = '0;
    ack            = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    timeout_err    = 1'b0;
`endif
    case (state)
      ARB_IDLE:    if (any_valid) next_state = ARB_POLL;
      ARB_POLL: begin
        uart_cs        = 1'b0;
        uart_rd_strobe = 1'b1;
        next_state     = ARB_CAPTURE;
      end
      ARB_CAPTURE: begin
        uart_cs = 1'b0;
        if (uart_rd_busy) begin
          if (uart_rdata[CTL_TX_BUSY]) next_state = (POLL_GAP == 0) ? ARB_POLL : ARB_GAP;
          else                         next_state = ARB_WRITE;
        end
      end
      ARB_GAP:     if (gap_cnt == '0) next_state = ARB_POLL;
      ARB_WRITE: begin
        uart_cs    = 1'b0;
        uart_wr    = 1'b0;
        uart_addr  = UART_ADDR_TX;
        uart_wdata = data_q;
        ack        = 1'b1;
        next_state = ARB_SETTLE;
      end
      ARB_SETTLE:  next_state = ARB_IDLE;
      default:     next_state = ARB_IDLE;
    endcase
`ifdef UART_ARB_TIMEOUT_EN
    // Abort takes priority over whatever bus cycle the poll loop was in.
    if (polling && tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
      next_state     = ARB_IDLE;
      uart_cs        = 1'b1;
      uart_rd_strobe = 1'b0;
      ack            = 1'b1;
      timeout_err    = 1'b1;
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = ack && (grant_id == 3'(i));
    end
  end

  assign busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with a behavioural UART
// control-register model; covers UART_ARB_TIMEOUT_EN when defined.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int POLL_GAP = 2;
  localparam int TMO = 50;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*8-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 uart_cs, uart_wr, uart_rd_strobe;
  logic                 uart_rd_busy = 1'b0;
  logic [2:0]           uart_addr;
  logic [7:0]           uart_wdata;
  logic [7:0]           uart_rdata = '0;
`ifdef UART_ARB_TIMEOUT_EN
  logic                 timeout_err;
`endif

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .POLL_GAP(POLL_GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .grant_id       (grant_id),
    .busy           (busy),
    .uart_cs        (uart_cs),
    .uart_wr        (uart_wr),
    .uart_rd_strobe (uart_rd_strobe),
    .uart_rd_busy   (uart_rd_busy),
    .uart_addr      (uart_addr),
    .uart_wdata     (uart_wdata),
    .uart_rdata     (uart_rdata)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .timeout_err    (timeout_err)
`endif
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- UART control-register model ----------------
  int poll_count = 0;
  int busy_until = 0;
  logic stuck = 1'b0;

  always @(posedge clock) begin
    if (!uart_cs && uart_rd_strobe) begin
      uart_rd_busy <= 1'b1;
      uart_rdata   <= {6'b0, (stuck || poll_count < busy_until), 1'b0};
      poll_count   <= poll_count + 1;
    end else begin
      uart_rd_busy <= 1'b0;
      uart_rdata   <= '0;
    end
  end

  // ---------------- scoreboard / checking ----------------
  logic [10:0] exp_q[$];
  int strobe_q[$];
  logic cs_hist[$];
  int write_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int write_cnt = 0;
  logic prev_strobe = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check bus-level properties there.
  task automatic tick();
    logic [10:0] e;
    @(negedge clock);
    cyc++;
    if (uart_rd_strobe === 1'b1) begin
      chk("strobe_consecutive", {31'b0, prev_strobe}, 32'd0);
      strobe_q.push_back(cyc);
    end
    prev_strobe = uart_rd_strobe;
    cs_hist.push_back(uart_cs);
    if (uart_wr !== 1'b1) begin
      write_cnt++;
      write_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {24'b0, uart_wdata}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {29'b0, uart_addr}, 32'd2);
        chk("write_cs", {31'b0, uart_cs}, 32'd0);
        chk("write_data", {24'b0, uart_wdata}, {24'b0, e[7:0]});
        chk("write_ready", {28'b0, req_ready}, 32'd1 << e[10:8]);
`ifdef UART_ARB_TIMEOUT_EN
        chk("write_timeout_err", {31'b0, timeout_err}, 32'd0);
`endif
      end
    end else if (req_ready !== '0) begin
`ifdef UART_ARB_TIMEOUT_EN
      chk("ready_needs_timeout", {31'b0, timeout_err}, 32'd1);
`else
      chk("ready_without_write", {28'b0, req_ready}, 32'd0);
`endif
    end
  endtask

  task automatic wait_writes(input int target, input int budget);
    for (int i = 0; i < budget && write_cnt < target; i++) tick();
    chk("wait_writes_bound", {31'b0, write_cnt >= target}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int s0, k, w0;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_cs", {31'b0, uart_cs}, 32'd1);
    chk("rst_wr", {31'b0, uart_wr}, 32'd1);
    chk("rst_strobe", {31'b0, uart_rd_strobe}, 32'd0);
    chk("rst_addr", {29'b0, uart_addr}, 32'd0);
    chk("rst_wdata", {24'b0, uart_wdata}, 32'd0);
    chk("rst_ready", {28'b0, req_ready}, 32'd0);
    chk("rst_grant", {29'b0, grant_id}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: single byte, UART idle: write on the third cycle after the request
    req_valid = 4'b0001;
    req_data  = 32'h0000_0041;
    exp_q.push_back({3'd0, 8'h41});
    repeat (3) tick();
    chk("t1_wr_low_cycle3", {31'b0, uart_wr}, 32'd0);
    chk("t1_ready_cycle3", {28'b0, req_ready}, 32'd1);
    req_valid = '0;
    tick();
    chk("t1_busy_settle", {31'b0, busy}, 32'd1);
    chk("t1_ready_once", {28'b0, req_ready}, 32'd0);
    tick();
    chk("t1_busy_fall", {31'b0, busy}, 32'd0);

    // 2: three busy polls then a write; polls spaced by capture + 2 idle cycles
    busy_until = poll_count + 3;
    s0 = strobe_q.size();
    req_valid = 4'b0010;
    req_data  = 32'h0000_5200;
    exp_q.push_back({3'd1, 8'h52});
    wait_writes(2, 100);
    req_valid = '0;
    chk("t2_strobe_count", strobe_q.size() - s0, 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (s0 + i + 1 < strobe_q.size()) begin
        chk("t2_strobe_spacing", strobe_q[s0+i+1] - strobe_q[s0+i], 32'd4);
        chk("t2_capture_cs", {31'b0, cs_hist[strobe_q[s0+i]]}, 32'd0);
        chk("t2_gap_idle_a", {31'b0, cs_hist[strobe_q[s0+i]+1]}, 32'd1);
        chk("t2_gap_idle_b", {31'b0, cs_hist[strobe_q[s0+i]+2]}, 32'd1);
      end
    end
    repeat (3) tick();
    chk("t2_grant_hold", {29'b0, grant_id}, 32'd1);
    chk("t2_idle", {31'b0, busy}, 32'd0);

    // 4: reset while capturing the status read; byte dropped, no write
    req_valid = 4'b0100;
    req_data  = 32'h0077_0000;
    repeat (2) tick();
    chk("t4_in_capture_cs", {31'b0, uart_cs}, 32'd0);
    chk("t4_in_capture_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    chk("t4_rst_cs", {31'b0, uart_cs}, 32'd1);
    chk("t4_rst_busy", {31'b0, busy}, 32'd0);
    chk("t4_rst_grant", {29'b0, grant_id}, 32'd0);
    reset = 1'b0;
    req_valid = '0;
    repeat (4) tick();

    // 3: round robin with all requesters holding valid
    req_data  = 32'h1312_1110;
    req_valid = 4'b1111;
    w0 = write_cnt;
    exp_q.push_back({3'd0, 8'h10});
    exp_q.push_back({3'd1, 8'h11});
    exp_q.push_back({3'd2, 8'h12});
    exp_q.push_back({3'd3, 8'h13});
    exp_q.push_back({3'd0, 8'h10});
    for (int i = 0; i < 100 && write_cnt < w0 + 5; i++) tick();
    req_valid = '0;
    chk("t3_write_count", write_cnt - w0, 32'd5);
    for (int i = 0; i < 4; i++) begin
      if (w0 + i + 1 < write_q.size())
        chk("t3_write_spacing", write_q[w0+i+1] - write_q[w0+i], 32'd5);
    end
    repeat (4) tick();

`ifdef UART_ARB_TIMEOUT_EN
    // 5: TX_BUSY stuck: requester 1 times out, requester 0 is served next
    stuck = 1'b1;
    req_data  = 32'h0000_A1A0;
    req_valid = 4'b0011;
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (req_ready !== '0) begin
        k = i;
        break;
      end
    end
    chk("t5_timeout_cycle", k, TMO + 1);
    chk("t5_timeout_ready", {28'b0, req_ready}, 32'b0010);
    chk("t5_timeout_err", {31'b0, timeout_err}, 32'd1);
    chk("t5_no_write", {31'b0, uart_wr}, 32'd1);
    req_valid = 4'b0001;
    stuck = 1'b0;
    exp_q.push_back({3'd0, 8'hA0});
    tick();
    chk("t5_err_pulse", {31'b0, timeout_err}, 32'd0);
    wait_writes(write_cnt + 1, 100);
    req_valid = '0;
`else
    // 5: TX_BUSY stuck: polling continues with no write or ack
    stuck = 1'b1;
    req_data  = 32'h0000_B100;
    req_valid = 4'b0010;
    w0 = write_cnt;
    repeat (200) tick();
    chk("t5_still_busy", {31'b0, busy}, 32'd1);
    chk("t5_no_write", write_cnt - w0, 32'd0);
    stuck = 1'b0;
    exp_q.push_back({3'd1, 8'hB1});
    wait_writes(w0 + 1, 100);
    req_valid = '0;
`endif
    repeat (4) tick();
    chk("final_idle", {31'b0, busy}, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
